// File: rtl/regfile_sweep.sv
// regfile_sweep: parametrised register file with two combinational read
// ports, one synchronous write port, optional write-through bypass, optional
// hardwired-zero entry 0, and a one-entry-per-cycle clear engine so the
// array itself carries no reset and can still map onto RAM.
module regfile_sweep #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          ready,
    input  logic [AW-1:0] a1,
    input  logic [AW-1:0] a2,
    input  logic [AW-1:0] aw,
    input  logic          we,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] r1,
    output logic [DW-1:0] r2
);

    // state | meaning
    // CLEAR | sweep counter walks the array writing zeros; reads return 0,
    //       | user writes ignored, ready low
    // RUN   | array valid; writes accepted, reads served, ready high

    localparam int            DEPTH = 1 << AW;
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t        state;
    logic [AW-1:0] cnt;

    logic [DW-1:0] mem [DEPTH];

    logic          sweep_we;
    logic          user_we;
    logic          r0_hit_w;

    // Sequencing FSM: sweep counter, state and registered ready flag.
    // A clear request always restarts the sweep from entry 0, whether it
    // arrives mid-sweep or during normal operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        state <= RUN;
                        cnt   <= '0;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Array write qualification: the sweep owns the write port while
    // clearing; a user write needs RUN, no concurrent clear, and (when
    // entry 0 is hardwired) a non-zero address.
    always_comb begin
        r0_hit_w = (ZERO_R0 != 0) && (aw == '0);
        sweep_we = (state == CLEAR);
        user_we  = (state == RUN) && we && !clr && !r0_hit_w;
    end

    // Storage array, deliberately without reset so it can infer as RAM.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[cnt] <= '0;
        end else if (user_we) begin
            mem[aw] <= din;
        end
    end

    // Per-port read resolution, highest priority first: not ready, entry 0
    // hardwired, bypass of the in-flight write, then the stored word.
    function automatic logic [DW-1:0] read_port(input logic [AW-1:0] addr);
        logic [DW-1:0] val;
        if (!ready) begin
            val = '0;
        end else if ((ZERO_R0 != 0) && (addr == '0)) begin
            val = '0;
        end else if ((BYPASS != 0) && we && (aw == addr)) begin
            val = din;
        end else begin
            val = mem[addr];
        end
        return val;
    endfunction

    // Read port 1.
    always_comb begin
        r1 = read_port(a1);
    end

    // Read port 2.
    always_comb begin
        r2 = read_port(a2);
    end

endmodule

// File: tb/tb_regfile_sweep.sv
// Directed bench for regfile_sweep. Three instances share the inputs:
// defaults, bypass disabled, and entry 0 not hardwired.
module tb_regfile_sweep;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  aw;
    logic        we;
    logic [31:0] din;

    logic        ready_d, ready_nb, ready_nz;
    logic [31:0] r1_d, r2_d, r1_nb, r2_nb, r1_nz, r2_nz;

    int checks = 0;
    int errors = 0;

    regfile_sweep u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready_d),
        .a1(a1), .a2(a2), .aw(aw), .we(we), .din(din),
        .r1(r1_d), .r2(r2_d)
    );

    regfile_sweep #(.BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready_nb),
        .a1(a1), .a2(a2), .aw(aw), .we(we), .din(din),
        .r1(r1_nb), .r2(r2_nb)
    );

    regfile_sweep #(.ZERO_R0(0)) u_nz (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready_nz),
        .a1(a1), .a2(a2), .aw(aw), .we(we), .din(din),
        .r1(r1_nz), .r2(r2_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        we    = 1'b0;
        a1    = '0;
        a2    = '0;
        aw    = '0;
        din   = '0;

        #2;
        chk("rst_ready", {31'd0, ready_d}, 32'd0);
        chk("rst_r1", r1_d, 32'd0);

        // Release reset and count the sweep edges.
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i);
            a2 = 5'(31 - i);
            #1;
            chk("sweep0_ready", {31'd0, ready_d}, 32'd0);
            chk("sweep0_r1", r1_d, 32'd0);
            chk("sweep0_r2", r2_d, 32'd0);
            tick();
        end
        #1;
        chk("sweep0_done_d", {31'd0, ready_d}, 32'd1);
        chk("sweep0_done_nb", {31'd0, ready_nb}, 32'd1);
        chk("sweep0_done_nz", {31'd0, ready_nz}, 32'd1);

        // Preload every entry with 0xDEADBEEF.
        for (int i = 0; i < 32; i++) begin
            we  = 1'b1;
            aw  = 5'(i);
            din = 32'hDEADBEEF;
            tick();
        end
        we = 1'b0;
        a1 = 5'd3;
        #1;
        chk("preload_r3", r1_d, 32'hDEADBEEF);
        a1 = 5'd0;
        #1;
        chk("preload_r0_zero", r1_d, 32'd0);
        chk("preload_r0_nz", r1_nz, 32'hDEADBEEF);

        // Asynchronous reset mid-run: ready drops before any clock edge.
        rst_n = 1'b0;
        #1;
        chk("async_rst_ready", {31'd0, ready_d}, 32'd0);
        chk("async_rst_r1_nz", r1_nz, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (31) tick();
        #1;
        chk("sweep1_ready31", {31'd0, ready_d}, 32'd0);
        tick();
        #1;
        chk("sweep1_ready32", {31'd0, ready_d}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i);
            a2 = 5'(i);
            #1;
            chk("cleared_d", r1_d, 32'd0);
            chk("cleared_nz", r2_nz, 32'd0);
        end

        // Write-through bypass vs. no bypass.
        we  = 1'b1;
        aw  = 5'd5;
        din = 32'h12345678;
        a1  = 5'd5;
        a2  = 5'd6;
        #1;
        chk("bypass_r1", r1_d, 32'h12345678);
        chk("nobypass_r1", r1_nb, 32'd0);
        tick();
        we = 1'b0;
        a1 = 5'd0;
        a2 = 5'd5;
        #1;
        chk("after_wr_r2", r2_d, 32'h12345678);
        chk("after_wr_r2_nb", r2_nb, 32'h12345678);

        // Hardwired entry 0.
        we  = 1'b1;
        aw  = 5'd0;
        din = 32'hFFFFFFFF;
        a1  = 5'd0;
        #1;
        chk("r0_wr_cycle", r1_d, 32'd0);
        chk("r0_wr_cycle_nz", r1_nz, 32'hFFFFFFFF);
        tick();
        we = 1'b0;
        #1;
        chk("r0_after", r1_d, 32'd0);
        chk("r0_after_nz", r1_nz, 32'hFFFFFFFF);

        // Clear wins over a concurrent write.
        we  = 1'b1;
        aw  = 5'd7;
        din = 32'hA5A5A5A5;
        tick();
        we = 1'b0;
        a1 = 5'd7;
        #1;
        chk("r7_filled", r1_d, 32'hA5A5A5A5);
        clr = 1'b1;
        we  = 1'b1;
        aw  = 5'd9;
        din = 32'd1;
        tick();
        clr = 1'b0;
        we  = 1'b0;
        #1;
        chk("clr_ready_fall", {31'd0, ready_d}, 32'd0);
        repeat (31) tick();
        #1;
        chk("clr_ready31", {31'd0, ready_d}, 32'd0);
        tick();
        #1;
        chk("clr_ready32", {31'd0, ready_d}, 32'd1);
        a1 = 5'd7;
        a2 = 5'd9;
        #1;
        chk("clr_r7", r1_d, 32'd0);
        chk("clr_r9_dropped", r2_d, 32'd0);
        a1 = 5'd0;
        #1;
        chk("clr_r0_nz", r1_nz, 32'd0);

        // Restart the sweep at cnt=10; writes during CLEAR are ignored.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (10) tick();
        #1;
        chk("mid_sweep_ready", {31'd0, ready_d}, 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int k = 0; k < 32; k++) begin
            we  = 1'b1;
            aw  = (k < 20) ? 5'd31 : 5'd3;
            din = 32'h55;
            a1  = aw;
            #1;
            chk("restart_ready", {31'd0, ready_d}, 32'd0);
            chk("restart_r1", r1_d, 32'd0);
            tick();
        end
        we = 1'b0;
        #1;
        chk("restart_ready32", {31'd0, ready_d}, 32'd1);
        a1 = 5'd31;
        a2 = 5'd3;
        #1;
        chk("clear_wr_r31", r1_d, 32'd0);
        chk("clear_wr_r3", r2_d, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
